// File: rtl/calc_key_seq.sv
// Keypad front-end for a two-operand calculator: decodes PS/2 set-2 bytes and drives a shared ALU.
// Defining CALC_TIMEOUT_EN adds an EXEC watchdog of TO_CYCLES cycles.
module calc_key_seq #(
    parameter int MAX_DIGITS = 2,
    parameter int TO_CYCLES  = 255
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iKEY_VALID,
    input  logic [7:0]  iKEY_CODE,
    output logic        oALU_START,
    output logic [1:0]  oALU_OP,
    output logic [6:0]  oALU_A,
    output logic [6:0]  oALU_B,
    input  logic        iALU_DONE,
    input  logic [15:0] iALU_RESULT,
    output logic [15:0] oDISP,
    output logic        oBUSY,
    output logic        oERR
);
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    state_t      state_r, state_s;
    logic        key_valid_r;
    logic [7:0]  key_code_r;
    logic        brk_r, brk_s;
    logic [6:0]  a_r, a_s, b_r, b_s;
    logic [1:0]  cnt_a_r, cnt_a_s, cnt_b_r, cnt_b_s;
    logic [1:0]  op_r, op_s;
    logic [15:0] disp_r, disp_s;
    logic        err_r, err_s;
    logic        start_r, busy_r;
    logic        key_s, is_digit_s, is_op_s, is_enter_s, is_esc_s;
    logic [3:0]  digit_s;
    logic [1:0]  key_op_s;
    logic        timeout_s, result_ok_s;

    // Map the delayed scan code onto digit / operator / control classes.
    always_comb begin
        is_digit_s = 1'b0;
        is_op_s    = 1'b0;
        is_enter_s = 1'b0;
        is_esc_s   = 1'b0;
        digit_s    = 4'd0;
        key_op_s   = 2'b00;
        case (key_code_r)
            8'h45: begin is_digit_s = 1'b1; digit_s = 4'd0; end
            8'h16: begin is_digit_s = 1'b1; digit_s = 4'd1; end
            8'h1E: begin is_digit_s = 1'b1; digit_s = 4'd2; end
            8'h26: begin is_digit_s = 1'b1; digit_s = 4'd3; end
            8'h25: begin is_digit_s = 1'b1; digit_s = 4'd4; end
            8'h2E: begin is_digit_s = 1'b1; digit_s = 4'd5; end
            8'h36: begin is_digit_s = 1'b1; digit_s = 4'd6; end
            8'h3D: begin is_digit_s = 1'b1; digit_s = 4'd7; end
            8'h3E: begin is_digit_s = 1'b1; digit_s = 4'd8; end
            8'h46: begin is_digit_s = 1'b1; digit_s = 4'd9; end
            8'h79: begin is_op_s = 1'b1; key_op_s = 2'b00; end
            8'h7B: begin is_op_s = 1'b1; key_op_s = 2'b01; end
            8'h7C: begin is_op_s = 1'b1; key_op_s = 2'b10; end
            8'h5A: is_enter_s = 1'b1;
            8'h76: is_esc_s = 1'b1;
            default: begin end
        endcase
    end

    // Break flag: set by F0, swallows exactly the following byte.
    always_comb begin
        if (!key_valid_r) begin
            brk_s = brk_r;
        end else if (brk_r) begin
            brk_s = 1'b0;
        end else if (key_code_r == 8'hF0) begin
            brk_s = 1'b1;
        end else begin
            brk_s = brk_r;
        end
    end

    assign key_s = key_valid_r && !brk_r && (key_code_r != 8'hF0) && (key_code_r != 8'hE0);
    assign result_ok_s = (disp_r[15:7] == 9'd0) && (disp_r[6:0] <= 7'd99);

`ifdef CALC_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_r;

    // Cycles spent in EXEC; restarts from zero on every entry.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            to_cnt_r <= '0;
        end else if (state_r == EXEC) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == EXEC) && (to_cnt_r == TW'(TO_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and operand/display updates; ESC overrides everything including ALU done.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        cnt_a_s = cnt_a_r;
        cnt_b_s = cnt_b_r;
        op_s    = op_r;
        disp_s  = disp_r;
        err_s   = err_r;
        if (key_s && is_esc_s) begin
            state_s = ENTER_A;
            a_s     = 7'd0;
            b_s     = 7'd0;
            cnt_a_s = 2'd0;
            cnt_b_s = 2'd0;
            disp_s  = 16'd0;
            err_s   = 1'b0;
        end else begin
            case (state_r)
                ENTER_A: begin
                    if (key_s && is_digit_s && (cnt_a_r < MAX_CNT)) begin
                        a_s     = a_r * 7'd10 + {3'd0, digit_s};
                        cnt_a_s = cnt_a_r + 2'd1;
                    end else if (key_s && is_op_s) begin
                        op_s    = key_op_s;
                        b_s     = 7'd0;
                        cnt_b_s = 2'd0;
                        state_s = ENTER_B;
                    end else begin
                        state_s = ENTER_A;
                    end
                end
                ENTER_B: begin
                    if (key_s && is_digit_s && (cnt_b_r < MAX_CNT)) begin
                        b_s     = b_r * 7'd10 + {3'd0, digit_s};
                        cnt_b_s = cnt_b_r + 2'd1;
                    end else if (key_s && is_op_s) begin
                        op_s = key_op_s;
                    end else if (key_s && is_enter_s) begin
                        state_s = EXEC;
                    end else begin
                        state_s = ENTER_B;
                    end
                end
                EXEC: begin
                    if (iALU_DONE) begin
                        disp_s  = iALU_RESULT;
                        state_s = SHOW;
                    end else if (timeout_s) begin
                        disp_s  = 16'hFFFF;
                        err_s   = 1'b1;
                        state_s = SHOW;
                    end else begin
                        state_s = EXEC;
                    end
                end
                SHOW: begin
                    if (key_s && is_digit_s) begin
                        a_s     = {3'd0, digit_s};
                        cnt_a_s = 2'd1;
                        b_s     = 7'd0;
                        cnt_b_s = 2'd0;
                        state_s = ENTER_A;
                    end else if (key_s && is_op_s && result_ok_s) begin
                        a_s     = disp_r[6:0];
                        op_s    = key_op_s;
                        b_s     = 7'd0;
                        cnt_b_s = 2'd0;
                        state_s = ENTER_B;
                    end else if (key_s && is_op_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = SHOW;
                    end
                end
                default: state_s = ENTER_A;
            endcase
        end
        // While an operand is being typed the display tracks it.
        case (state_s)
            ENTER_A: disp_s = {9'd0, a_s};
            ENTER_B: disp_s = {9'd0, b_s};
            default: begin end
        endcase
    end

    // Key pipeline stage plus all state and output registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_valid_r <= 1'b0;
            key_code_r  <= 8'h00;
            brk_r       <= 1'b0;
            state_r     <= ENTER_A;
            a_r         <= 7'd0;
            b_r         <= 7'd0;
            cnt_a_r     <= 2'd0;
            cnt_b_r     <= 2'd0;
            op_r        <= 2'b00;
            disp_r      <= 16'd0;
            err_r       <= 1'b0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            key_valid_r <= iKEY_VALID;
            key_code_r  <= iKEY_CODE;
            brk_r       <= brk_s;
            state_r     <= state_s;
            a_r         <= a_s;
            b_r         <= b_s;
            cnt_a_r     <= cnt_a_s;
            cnt_b_r     <= cnt_b_s;
            op_r        <= op_s;
            disp_r      <= disp_s;
            err_r       <= err_s;
            start_r     <= (state_s == EXEC) && (state_r != EXEC);
            busy_r      <= (state_s == EXEC);
        end
    end

    assign oALU_START = start_r;
    assign oALU_OP    = op_r;
    assign oALU_A     = a_r;
    assign oALU_B     = b_r;
    assign oDISP      = disp_r;
    assign oBUSY      = busy_r;
    assign oERR       = err_r;
endmodule

// File: tb/tb_calc_key_seq.sv
// Self-checking bench for calc_key_seq: key-vector table plus ALU handshake sequences.
module tb_calc_key_seq;
    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iKEY_VALID = 1'b0;
    logic [7:0]  iKEY_CODE = 8'h00;
    logic        iALU_DONE = 1'b0;
    logic [15:0] iALU_RESULT = 16'h0000;
    logic        oALU_START;
    logic [1:0]  oALU_OP;
    logic [6:0]  oALU_A, oALU_B;
    logic [15:0] oDISP;
    logic        oBUSY, oERR;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int cyc;

    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
        logic [1:0] op;
    } alu_exp_t;
    alu_exp_t exp_q[$];
    alu_exp_t mon_e;

    typedef struct packed {
        logic [47:0] keys;
        logic [2:0]  nk;
        logic [6:0]  ea;
        logic [6:0]  eb;
        logic [1:0]  eop;
        logic [15:0] edisp;
    } vec_t;
    vec_t vecs[10];

    calc_key_seq dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iKEY_VALID(iKEY_VALID), .iKEY_CODE(iKEY_CODE),
        .oALU_START(oALU_START), .oALU_OP(oALU_OP), .oALU_A(oALU_A), .oALU_B(oALU_B),
        .iALU_DONE(iALU_DONE), .iALU_RESULT(iALU_RESULT), .oDISP(oDISP), .oBUSY(oBUSY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Key strobe for one cycle, then wait until the key has been processed.
    task automatic send_key(input logic [7:0] c);
        iKEY_VALID = 1'b1;
        iKEY_CODE  = c;
        @(posedge iCLK); #1;
        iKEY_VALID = 1'b0;
        @(posedge iCLK); #1;
    endtask

    task automatic alu_done(input logic [15:0] r);
        iALU_DONE   = 1'b1;
        iALU_RESULT = r;
        @(posedge iCLK); #1;
        iALU_DONE = 1'b0;
    endtask

    // Scoreboard consumer: each ALU start pops the operands expected at ENTER time.
    always @(negedge iCLK) begin
        if (iRST_n && oALU_START) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                chk("alu_start_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("alu_a", {25'd0, oALU_A}, {25'd0, mon_e.a});
                chk("alu_b", {25'd0, oALU_B}, {25'd0, mon_e.b});
                chk("alu_op", {30'd0, oALU_OP}, {30'd0, mon_e.op});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // keys, count, A, B, OP, DISP; ESC does not touch OP, so it carries over
        vecs[0] = '{48'h161E_0000_0000, 3'd2, 7'd12, 7'd0,  2'b00, 16'h000C};
        vecs[1] = '{48'h16F0_161E_0000, 3'd4, 7'd12, 7'd0,  2'b00, 16'h000C};
        vecs[2] = '{48'h4646_4600_0000, 3'd3, 7'd99, 7'd0,  2'b00, 16'h0063};
        vecs[3] = '{48'h257B_362E_0000, 3'd4, 7'd4,  7'd65, 2'b01, 16'h0041};
        vecs[4] = '{48'h7C3D_0000_0000, 3'd2, 7'd0,  7'd7,  2'b10, 16'h0007};
        vecs[5] = '{48'hE026_2600_0000, 3'd3, 7'd33, 7'd0,  2'b10, 16'h0021};
        vecs[6] = '{48'h5A16_791E_7B00, 3'd5, 7'd1,  7'd2,  2'b01, 16'h0002};
        vecs[7] = '{48'h16F0_792E_0000, 3'd4, 7'd15, 7'd0,  2'b01, 16'h000F};
        vecs[8] = '{48'h1C16_5500_0000, 3'd3, 7'd1,  7'd0,  2'b01, 16'h0001};
        vecs[9] = '{48'h7946_4646_0000, 3'd4, 7'd0,  7'd99, 2'b00, 16'h0063};

        #12;
        chk("rst_start", {31'd0, oALU_START}, 32'd0);
        chk("rst_busy", {31'd0, oBUSY}, 32'd0);
        chk("rst_err", {31'd0, oERR}, 32'd0);
        chk("rst_disp", {16'd0, oDISP}, 32'd0);
        chk("rst_ab_op", {16'd0, oALU_A, oALU_B, oALU_OP}, 32'd0);
        @(posedge iCLK); #1;
        iRST_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send_key(8'h76);
            for (int k = 0; k < int'(vecs[i].nk); k++) begin
                send_key(vecs[i].keys[47-8*k -: 8]);
            end
            chk($sformatf("vec%0d_a", i), {25'd0, oALU_A}, {25'd0, vecs[i].ea});
            chk($sformatf("vec%0d_b", i), {25'd0, oALU_B}, {25'd0, vecs[i].eb});
            chk($sformatf("vec%0d_op", i), {30'd0, oALU_OP}, {30'd0, vecs[i].eop});
            chk($sformatf("vec%0d_disp", i), {16'd0, oDISP}, {16'd0, vecs[i].edisp});
            chk($sformatf("vec%0d_err", i), {31'd0, oERR}, 32'd0);
            chk($sformatf("vec%0d_busy", i), {31'd0, oBUSY}, 32'd0);
        end

        // 12 + 3, result 15, then chain with '*'
        send_key(8'h76); send_key(8'h16); send_key(8'h1E); send_key(8'h79); send_key(8'h26);
        exp_q.push_back('{7'd12, 7'd3, 2'b00});
        cyc = start_cnt;
        send_key(8'h5A);
        chk("exec_busy", {31'd0, oBUSY}, 32'd1);
        repeat (4) @(posedge iCLK);
        #1;
        chk("start_once", cyc + 1, start_cnt);
        chk("hold_a", {25'd0, oALU_A}, 32'd12);
        chk("hold_b", {25'd0, oALU_B}, 32'd3);
        alu_done(16'h000F);
        chk("show_disp", {16'd0, oDISP}, 32'h000F);
        chk("show_busy", {31'd0, oBUSY}, 32'd0);
        send_key(8'h7C);
        chk("chain15_a", {25'd0, oALU_A}, 32'd15);
        chk("chain15_op", {30'd0, oALU_OP}, 32'd2);
        chk("chain15_disp", {16'd0, oDISP}, 32'd0);

        // 99 * 2 = 200 is out of range for chaining
        send_key(8'h76); send_key(8'h46); send_key(8'h46); send_key(8'h7C); send_key(8'h1E);
        exp_q.push_back('{7'd99, 7'd2, 2'b10});
        send_key(8'h5A);
        alu_done(16'h00C8);
        chk("c8_disp", {16'd0, oDISP}, 32'h00C8);
        send_key(8'h79);
        chk("c8_err", {31'd0, oERR}, 32'd1);
        chk("c8_disp_kept", {16'd0, oDISP}, 32'h00C8);
        chk("c8_op_kept", {30'd0, oALU_OP}, 32'd2);
        send_key(8'h36);
        chk("show_digit_a", {25'd0, oALU_A}, 32'd6);
        chk("show_digit_disp", {16'd0, oDISP}, 32'd6);
        send_key(8'h76); send_key(8'h1E); send_key(8'h79); send_key(8'h26);
        exp_q.push_back('{7'd2, 7'd3, 2'b00});
        send_key(8'h5A);
        alu_done(16'h0005);
        send_key(8'h7C);
        chk("chain5_a", {25'd0, oALU_A}, 32'd5);
        chk("chain5_op", {30'd0, oALU_OP}, 32'd2);
        chk("chain5_b", {25'd0, oALU_B}, 32'd0);
        chk("chain5_err", {31'd0, oERR}, 32'd0);
        send_key(8'h25);
        chk("chain5_b4", {16'd0, oDISP}, 32'd4);

        // ESC and ALU done land on the same processing cycle
        send_key(8'h76); send_key(8'h16); send_key(8'h79); send_key(8'h16);
        exp_q.push_back('{7'd1, 7'd1, 2'b00});
        send_key(8'h5A);
        iKEY_VALID = 1'b1;
        iKEY_CODE  = 8'h76;
        @(posedge iCLK); #1;
        iKEY_VALID  = 1'b0;
        iALU_DONE   = 1'b1;
        iALU_RESULT = 16'h0002;
        @(posedge iCLK); #1;
        iALU_DONE = 1'b0;
        chk("escwin_busy", {31'd0, oBUSY}, 32'd0);
        chk("escwin_disp", {16'd0, oDISP}, 32'd0);
        chk("escwin_err", {31'd0, oERR}, 32'd0);
        alu_done(16'h1234);
        chk("done_ignored", {16'd0, oDISP}, 32'd0);
        send_key(8'h3D);
        chk("after_esc_a", {25'd0, oALU_A}, 32'd7);

        // EXEC with no ALU response
        send_key(8'h76); send_key(8'h16); send_key(8'h79); send_key(8'h16);
        exp_q.push_back('{7'd1, 7'd1, 2'b00});
        send_key(8'h5A);
`ifdef CALC_TIMEOUT_EN
        cyc = 0;
        while (oBUSY && cyc < 400) begin
            @(posedge iCLK); #1;
            cyc++;
        end
        chk("to_cycles", cyc, 32'd255);
        chk("to_err", {31'd0, oERR}, 32'd1);
        chk("to_disp", {16'd0, oDISP}, 32'hFFFF);
`else
        repeat (300) @(posedge iCLK);
        #1;
        chk("wait_busy", {31'd0, oBUSY}, 32'd1);
`endif
        send_key(8'h76);
        chk("leave_busy", {31'd0, oBUSY}, 32'd0);
        chk("leave_disp", {16'd0, oDISP}, 32'd0);

        // Reset pulsed in the middle of EXEC
        send_key(8'h16); send_key(8'h79); send_key(8'h16);
        exp_q.push_back('{7'd1, 7'd1, 2'b00});
        send_key(8'h5A);
        repeat (3) @(posedge iCLK);
        #1;
        iRST_n = 1'b0;
        #2;
        chk("mrst_busy", {31'd0, oBUSY}, 32'd0);
        chk("mrst_start", {31'd0, oALU_START}, 32'd0);
        chk("mrst_disp", {16'd0, oDISP}, 32'd0);
        chk("mrst_err", {31'd0, oERR}, 32'd0);
        chk("mrst_ab_op", {16'd0, oALU_A, oALU_B, oALU_OP}, 32'd0);
        @(posedge iCLK); #1;
        iRST_n = 1'b1;
        alu_done(16'h0042);
        chk("mrst_done_ignored", {16'd0, oDISP}, 32'd0);
        chk("mrst_idle", {31'd0, oBUSY}, 32'd0);

        repeat (2) @(posedge iCLK);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        chk("start_total", start_cnt, 32'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
